// File: rtl/floo_mcast_fork_ctrl.sv
// floo_mcast_fork_ctrl
//
// Multicast fork for the router output stage. One input flit stream, tagged
// with a destination-port mask, is replicated to every selected output. Each
// output may accept at a different cycle. The input is released only once all
// selected outputs have taken the flit. The mask is locked from the head flit
// to the last flit of a wormhole burst. A watchdog flags prolonged
// back-pressure on the input.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   valid_i/ready_o   input flit handshake
//   data_i            input flit (passed through unmodified)
//   mask_i            destination mask, sampled on head flits only
//   last_i            flit closes its burst
//   valid_o/ready_i   per-output handshake (NumOut lanes)
//   data_o            per-output flit, every lane equals data_i
//   drop_o            flit consumed with an empty effective mask
//   busy_o            inside a multi-flit burst
//   stall_o           input back-pressured for StallThreshold+ cycles
module floo_mcast_fork_ctrl #(
    parameter int unsigned NumOut         = 5,
    parameter type         flit_t         = logic [63:0],
    parameter int unsigned StallThreshold = 256,
    parameter int unsigned StallCntWidth  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  flit_t               data_i,
    input  logic [NumOut-1:0]   mask_i,
    input  logic                last_i,
    output logic [NumOut-1:0]   valid_o,
    input  logic [NumOut-1:0]   ready_i,
    output flit_t [NumOut-1:0]  data_o,
    output logic                drop_o,
    output logic                busy_o,
    output logic                stall_o
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam logic [StallCntWidth-1:0] CntMax = {StallCntWidth{1'b1}};
    localparam logic [StallCntWidth-1:0] CntThr = StallCntWidth'(StallThreshold);

    state_t                   state_q, state_d;
    logic [NumOut-1:0]        mask_q, mask_d;
    logic [NumOut-1:0]        sent_q, sent_d;
    logic [StallCntWidth-1:0] cnt_q, cnt_d;

    logic [NumOut-1:0] eff_mask;
    logic [NumOut-1:0] offer;
    logic [NumOut-1:0] take;
    logic              done;
    logic              accept;

    // Offer and completion logic: an output is offered the flit until it has
    // taken it; the input completes once every selected lane is either
    // already served or taking the flit in this cycle.
    always_comb begin
        eff_mask = (state_q == BURST) ? mask_q : mask_i;
        offer    = {NumOut{valid_i}} & eff_mask & ~sent_q;
        take     = offer & ready_i;
        done     = &(~eff_mask | sent_q | take);
        accept   = valid_i & done;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sent_d  = sent_q | take;
        cnt_d   = '0;

        if (accept) begin
            // A handshake that also carries the final lane clears sent_q
            // rather than setting it, so the next flit starts fresh.
            sent_d = '0;
            if (state_q == IDLE) begin
                if (!last_i) begin
                    state_d = BURST;
                    mask_d  = eff_mask;
                end
            end else if (last_i) begin
                state_d = IDLE;
            end
        end

        if (valid_i && !accept) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mask_q  <= '0;
            sent_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sent_q  <= sent_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control outputs are held low while reset is asserted so that neither
    // side sees a handshake during reset; data lanes are left ungated.
    always_comb begin
        ready_o = rst_ni & accept;
        valid_o = {NumOut{rst_ni}} & offer;
        drop_o  = rst_ni & accept & (eff_mask == '0);
        busy_o  = rst_ni & (state_q == BURST);
        stall_o = rst_ni & (cnt_q >= CntThr);
        for (int j = 0; j < NumOut; j++) begin
            data_o[j] = data_i;
        end
    end

endmodule

// File: tb/tb_floo_mcast_fork_ctrl.sv
module tb_floo_mcast_fork_ctrl;

    localparam int N = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              valid_i;
    logic              ready_o;
    logic [63:0]       data_i;
    logic [N-1:0]      mask_i;
    logic              last_i;
    logic [N-1:0]      valid_o;
    logic [N-1:0]      ready_i;
    logic [N-1:0][63:0] data_o;
    logic              drop_o;
    logic              busy_o;
    logic              stall_o;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q [N][$];
    logic [63:0] drop_q [$];

    floo_mcast_fork_ctrl #(
        .NumOut        (N),
        .flit_t        (logic [63:0]),
        .StallThreshold(8),
        .StallCntWidth (16)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .mask_i (mask_i),
        .last_i (last_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .drop_o (drop_o),
        .busy_o (busy_o),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [N-1:0] m,
                         input logic l, input logic [N-1:0] r);
        valid_i = v;
        data_i  = d;
        mask_i  = m;
        last_i  = l;
        ready_i = r;
    endtask

    task automatic to_neg();
        @(negedge clk_i);
    endtask

    task automatic to_next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_lanes(input logic [N-1:0] m, input logic [63:0] d);
        for (int j = 0; j < N; j++) begin
            if (m[j]) exp_q[j].push_back(d);
        end
    endtask

    // Monitor: every output handshake must match the next expected flit of
    // that lane; every drop pulse must match the next expected dropped flit.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int j = 0; j < N; j++) begin
                if (valid_o[j] && ready_i[j]) begin
                    if (exp_q[j].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL lane%0d_extra: got flit %h, required none", j, data_o[j]);
                    end else begin
                        chk($sformatf("lane%0d_data", j), data_o[j], exp_q[j].pop_front());
                    end
                end
            end
            if (drop_o) begin
                if (drop_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL drop_extra: got drop of %h, required none", data_i);
                end else begin
                    chk("drop_data", data_i, drop_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        drive(1'b1, 64'hDEAD, 5'b11111, 1'b1, 5'b11111);

        // Reset: all control outputs forced low even with valid input.
        to_neg();
        chk("rst_ready", ready_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_drop", drop_o, 0);
        to_next();
        drive(1'b0, 0, 0, 1'b0, 0);
        rst_ni = 1'b1;
        to_next();

        // Single-flit unicast.
        drive(1'b1, 64'hA0, 5'b00100, 1'b1, 5'b11111);
        push_lanes(5'b00100, 64'hA0);
        to_neg();
        chk("uni_valid", valid_o, 5'b00100);
        chk("uni_ready", ready_o, 1);
        chk("uni_busy", busy_o, 0);
        to_next();
        drive(1'b0, 0, 0, 1'b0, 0);
        to_next();

        // Staggered multicast; lane 0 stays ready to catch a repeated offer.
        push_lanes(5'b10011, 64'hB0);
        drive(1'b1, 64'hB0, 5'b10011, 1'b1, 5'b00001);
        to_neg();
        chk("stag_c0_valid", valid_o, 5'b10011);
        chk("stag_c0_ready", ready_o, 0);
        to_next();
        ready_i = 5'b00001;
        to_neg();
        chk("stag_c1_valid", valid_o, 5'b10010);
        chk("stag_c1_ready", ready_o, 0);
        to_next();
        ready_i = 5'b00011;
        to_neg();
        chk("stag_c2_valid", valid_o, 5'b10010);
        chk("stag_c2_ready", ready_o, 0);
        to_next();
        to_neg();
        chk("stag_c3_valid", valid_o, 5'b10000);
        chk("stag_c3_ready", ready_o, 0);
        to_next();
        ready_i = 5'b11111;
        to_neg();
        chk("stag_c4_valid", valid_o, 5'b10000);
        chk("stag_c4_ready", ready_o, 1);
        to_next();
        drive(1'b0, 0, 0, 1'b0, 5'b11111);
        to_neg();
        chk("stag_after_valid", valid_o, 0);
        to_next();

        // Burst mask lock: body flits present a different mask.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'hC0 + 64'(i), (i == 0) ? 5'b01010 : 5'b00001, (i == 3), 5'b11111);
            push_lanes(5'b01010, 64'hC0 + 64'(i));
            to_neg();
            chk($sformatf("burst%0d_valid", i), valid_o, 5'b01010);
            chk($sformatf("burst%0d_ready", i), ready_o, 1);
            chk($sformatf("burst%0d_busy", i), busy_o, (i > 0));
            to_next();
        end
        drive(1'b0, 0, 0, 1'b0, 5'b11111);
        to_neg();
        chk("burst_end_busy", busy_o, 0);
        to_next();

        // Empty-mask burst: locked zero mask drops body flits too.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hD0 + 64'(i), (i == 0) ? 5'b00000 : 5'b11111, (i == 2), 5'b11111);
            drop_q.push_back(64'hD0 + 64'(i));
            to_neg();
            chk($sformatf("drop%0d_pulse", i), drop_o, 1);
            chk($sformatf("drop%0d_valid", i), valid_o, 0);
            chk($sformatf("drop%0d_ready", i), ready_o, 1);
            to_next();
        end
        drive(1'b0, 0, 0, 1'b0, 5'b11111);
        to_neg();
        chk("drop_end_busy", busy_o, 0);
        chk("drop_end_pulse", drop_o, 0);
        to_next();

        // Stall watchdog, threshold 8: stall counter equals the number of
        // back-pressured cycles already completed.
        push_lanes(5'b00001, 64'hE0);
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 64'hE0, 5'b00001, 1'b1, 5'b00000);
            to_neg();
            chk($sformatf("stall_c%0d", k), stall_o, (k >= 8));
            chk($sformatf("stall_c%0d_ready", k), ready_o, 0);
            to_next();
        end
        ready_i = 5'b00001;
        to_neg();
        chk("stall_hs_ready", ready_o, 1);
        chk("stall_hs_stall", stall_o, 1);
        to_next();
        drive(1'b0, 0, 0, 1'b0, 5'b11111);
        to_neg();
        chk("stall_cleared", stall_o, 0);
        to_next();

        // Reset mid-burst: two of four flits, then reset.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'hF0 + 64'(i), 5'b11111, 1'b0, 5'b11111);
            push_lanes(5'b11111, 64'hF0 + 64'(i));
            to_next();
        end
        rst_ni = 1'b0;
        to_neg();
        chk("mrst_valid", valid_o, 0);
        chk("mrst_ready", ready_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_drop", drop_o, 0);
        chk("mrst_stall", stall_o, 0);
        to_next();
        rst_ni = 1'b1;
        drive(1'b1, 64'h1234, 5'b00010, 1'b1, 5'b11111);
        push_lanes(5'b00010, 64'h1234);
        to_neg();
        chk("post_rst_valid", valid_o, 5'b00010);
        chk("post_rst_ready", ready_o, 1);
        chk("post_rst_busy", busy_o, 0);
        to_next();
        drive(1'b0, 0, 0, 1'b0, 0);
        repeat (3) to_next();

        for (int j = 0; j < N; j++) begin
            chk($sformatf("lane%0d_pending", j), exp_q[j].size(), 0);
        end
        chk("drop_pending", drop_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
